// File: rtl/bank_machine_pkg.sv
// Shared types for the per-bank command scheduler.
//   bm_state_t : scheduler FSM states
//   CMD_*      : DRAM command encodings as {cas, ras, we}
package bank_machine_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRECHARGE,
    AUTOPRE,
    ACTIVATE,
    REFRESH,
    TRP,
    TRCD
  } bm_state_t;

  localparam logic [2:0] CMD_NOP = 3'b000;
  localparam logic [2:0] CMD_ACT = 3'b010;
  localparam logic [2:0] CMD_PRE = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b100;
  localparam logic [2:0] CMD_WR  = 3'b101;

endpackage

// File: rtl/bank_machine_gen_if.sv
// Request / refresh / command bundle between the bank scheduler and its
// neighbours.
//   slave  : the bank machine (takes requests, issues commands)
//   master : the surrounding controller / bank multiplexer
interface bank_machine_gen_if #(
  parameter int ROW_W = 17,
  parameter int COL_W = 6,
  parameter int A_W   = 17,
  parameter int BA_W  = 3
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [ROW_W+COL_W-1:0] req_addr;
  logic                   req_lock;
  logic                   req_wdata_ready;
  logic                   req_rdata_valid;

  logic                   refresh_req;
  logic                   refresh_gnt;

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [A_W-1:0]         cmd_payload_a;
  logic [BA_W-1:0]        cmd_payload_ba;
  logic                   cmd_payload_cas;
  logic                   cmd_payload_ras;
  logic                   cmd_payload_we;
  logic                   cmd_payload_is_cmd;
  logic                   cmd_payload_is_read;
  logic                   cmd_payload_is_write;

  modport slave (
    input  req_valid, req_we, req_addr, refresh_req, cmd_ready,
    output req_ready, req_lock, req_wdata_ready, req_rdata_valid, refresh_gnt,
           cmd_valid, cmd_payload_a, cmd_payload_ba, cmd_payload_cas,
           cmd_payload_ras, cmd_payload_we, cmd_payload_is_cmd,
           cmd_payload_is_read, cmd_payload_is_write
  );

  modport master (
    output req_valid, req_we, req_addr, refresh_req, cmd_ready,
    input  req_ready, req_lock, req_wdata_ready, req_rdata_valid, refresh_gnt,
           cmd_valid, cmd_payload_a, cmd_payload_ba, cmd_payload_cas,
           cmd_payload_ras, cmd_payload_we, cmd_payload_is_cmd,
           cmd_payload_is_read, cmd_payload_is_write
  );
endinterface

// File: rtl/bank_machine_gen_timer.sv
// bm_timer: DRAM timing-constraint countdown.
//   load  : restart the constraint with cfg cycles (0 treated as 1)
//   ready : low from the cycle after load until max(cfg,1) cycles after it
module bm_timer #(
  parameter int TMR_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             load,
  input  logic [TMR_W-1:0] cfg,
  output logic             ready
);
  logic [TMR_W-1:0] count;

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      count <= '0;
      ready <= 1'b1;
    end else if (load) begin
      count <= (cfg == '0) ? '0 : cfg - 1'b1;
      ready <= 1'b0;
    end else if (!ready) begin
      if (count == '0) ready <= 1'b1;
      else             count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/bank_machine_gen.sv
// bank_machine_gen: per-bank command scheduler.
// Buffers requests in a DEPTH-entry lookahead FIFO plus one output stage,
// tracks the open row, enforces tRC/tRAS/tRP/tRCD/tWTP and issues
// ACT/PRE/RD/WR with a refresh handshake.
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   bus              : request / refresh / command bundle (slave side)
//   cfg_*            : timing constraints in cycles
// Optional: define BANK_MACHINE_STATS_EN to add stat_hits, stat_misses,
// stat_acts (32-bit saturating counters).
module bank_machine_gen
  import bank_machine_pkg::*;
#(
  parameter int BANK_ID    = 0,
  parameter int BA_W       = 3,
  parameter int ROW_W      = 17,
  parameter int COL_W      = 6,
  parameter int COL_SHIFT  = 4,
  parameter int A_W        = 17,
  parameter int AP_BIT     = 10,
  parameter int DEPTH      = 8,
  parameter int TMR_W      = 8,
  parameter int CLOSE_PAGE = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  bank_machine_gen_if.slave bus,
  input  logic [TMR_W-1:0]  cfg_twtp,
  input  logic [TMR_W-1:0]  cfg_trc,
  input  logic [TMR_W-1:0]  cfg_tras,
  input  logic [TMR_W-1:0]  cfg_trp,
  input  logic [TMR_W-1:0]  cfg_trcd
`ifdef BANK_MACHINE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_acts
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic             we;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } req_t;

  // ---------------- lookahead FIFO + output stage ----------------
  req_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   level;
  req_t             head, out_q;
  logic             out_valid;
  logic             fifo_empty, push, pop, out_load, consumed;
  logic             wr_acc, rd_acc;

  assign fifo_empty    = (level == '0);
  assign bus.req_ready = (level != FULL_LEVEL);
  assign push          = bus.req_valid & bus.req_ready;
  assign consumed      = wr_acc | rd_acc;
  assign out_load      = ~out_valid | consumed;
  assign pop           = ~fifo_empty & out_load;
  assign head          = mem[rd_ptr];
  assign bus.req_lock  = ~fifo_empty | out_valid;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: data storage is deliberately not reset; validity is carried by
  // level/out_valid, so stale contents are never observed.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= {bus.req_we, bus.req_addr};
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst)       out_valid <= 1'b0;
    else if (out_load) out_valid <= ~fifo_empty;
  end

  always_ff @(posedge sys_clk) begin
    if (out_load) out_q <= head;
  end

  // ---------------- open row tracking ----------------
  bm_state_t        state, state_nxt;
  logic             row_opened;
  logic [ROW_W-1:0] open_row;
  logic             row_hit, auto_precharge;
  logic             act_acc, pre_acc;

  assign row_hit = (open_row == out_q.row);
  // Close the row early when the next queued request targets another row.
  assign auto_precharge = (CLOSE_PAGE != 0) ? 1'b1
                        : (~fifo_empty & (head.row != out_q.row));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      row_opened <= 1'b0;
      open_row   <= '0;
    end else if (state == PRECHARGE || state == AUTOPRE || state == REFRESH) begin
      row_opened <= 1'b0;
    end else if (act_acc) begin
      row_opened <= 1'b1;
      open_row   <= out_q.row;
    end
  end

  // ---------------- timing constraints ----------------
  logic twtp_rdy, trc_rdy, tras_rdy, trp_rdy, trcd_rdy, ld_trp;

  assign ld_trp = pre_acc | (state == IDLE && state_nxt == AUTOPRE);

  bm_timer #(.TMR_W(TMR_W)) u_twtp (.sys_clk(sys_clk), .sys_rst(sys_rst), .load(wr_acc),  .cfg(cfg_twtp), .ready(twtp_rdy));
  bm_timer #(.TMR_W(TMR_W)) u_trc  (.sys_clk(sys_clk), .sys_rst(sys_rst), .load(act_acc), .cfg(cfg_trc),  .ready(trc_rdy));
  bm_timer #(.TMR_W(TMR_W)) u_tras (.sys_clk(sys_clk), .sys_rst(sys_rst), .load(act_acc), .cfg(cfg_tras), .ready(tras_rdy));
  bm_timer #(.TMR_W(TMR_W)) u_trp  (.sys_clk(sys_clk), .sys_rst(sys_rst), .load(ld_trp),  .cfg(cfg_trp),  .ready(trp_rdy));
  bm_timer #(.TMR_W(TMR_W)) u_trcd (.sys_clk(sys_clk), .sys_rst(sys_rst), .load(act_acc), .cfg(cfg_trcd), .ready(trcd_rdy));

  // ---------------- FSM ----------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.refresh_req)                          state_nxt = REFRESH;
        else if (out_valid) begin
          if (!row_opened)                            state_nxt = ACTIVATE;
          else if (!row_hit)                          state_nxt = PRECHARGE;
          else if (bus.cmd_ready && auto_precharge)   state_nxt = AUTOPRE;
        end
      end
      PRECHARGE: if (twtp_rdy && tras_rdy && bus.cmd_ready) state_nxt = TRP;
      AUTOPRE:   if (twtp_rdy && tras_rdy)                  state_nxt = TRP;
      ACTIVATE:  if (trc_rdy && bus.cmd_ready)              state_nxt = TRCD;
      TRP:       if (trp_rdy) state_nxt = out_valid ? ACTIVATE : IDLE;
      TRCD:      if (trcd_rdy)                              state_nxt = IDLE;
      REFRESH:   if (!bus.refresh_req)                      state_nxt = IDLE;
      default:                                              state_nxt = IDLE;
    endcase
  end

  logic sel_row;

  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would infer a latch.
  always_comb begin
    bus.cmd_valid            = 1'b0;
    bus.cmd_payload_cas      = 1'b0;
    bus.cmd_payload_ras      = 1'b0;
    bus.cmd_payload_we       = 1'b0;
    bus.cmd_payload_is_cmd   = 1'b0;
    bus.cmd_payload_is_read  = 1'b0;
    bus.cmd_payload_is_write = 1'b0;
    bus.refresh_gnt          = 1'b0;
    wr_acc                   = 1'b0;
    rd_acc                   = 1'b0;
    sel_row                  = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.refresh_req && out_valid && row_opened && row_hit) begin
          bus.cmd_valid            = 1'b1;
          bus.cmd_payload_cas      = 1'b1;
          bus.cmd_payload_we       = out_q.we;
          bus.cmd_payload_is_write = out_q.we;
          bus.cmd_payload_is_read  = ~out_q.we;
          wr_acc                   = bus.cmd_ready & out_q.we;
          rd_acc                   = bus.cmd_ready & ~out_q.we;
        end
      end
      PRECHARGE: begin
        if (twtp_rdy && tras_rdy) begin
          bus.cmd_valid          = 1'b1;
          bus.cmd_payload_ras    = 1'b1;
          bus.cmd_payload_we     = 1'b1;
          bus.cmd_payload_is_cmd = 1'b1;
        end
      end
      ACTIVATE: begin
        if (trc_rdy) begin
          bus.cmd_valid          = 1'b1;
          bus.cmd_payload_ras    = 1'b1;
          bus.cmd_payload_is_cmd = 1'b1;
          sel_row                = 1'b1;
        end
      end
      REFRESH: begin
        bus.cmd_payload_is_cmd = 1'b1;
        // Gated by the request so the grant drops together with it.
        bus.refresh_gnt        = bus.refresh_req & twtp_rdy & trp_rdy;
      end
      default: ;
    endcase
  end

  assign act_acc             = (state == ACTIVATE) & trc_rdy & bus.cmd_ready;
  assign pre_acc             = (state == PRECHARGE) & twtp_rdy & tras_rdy & bus.cmd_ready;
  assign bus.req_wdata_ready = wr_acc;
  assign bus.req_rdata_valid = rd_acc;
  assign bus.cmd_payload_ba  = BA_W'(BANK_ID);

  always_comb begin
    bus.cmd_payload_a = '0;
    if (sel_row) begin
      bus.cmd_payload_a = A_W'(out_q.row);
    end else if (bus.cmd_payload_cas) begin
      bus.cmd_payload_a         = A_W'({out_q.col, {COL_SHIFT{1'b0}}});
      bus.cmd_payload_a[AP_BIT] = auto_precharge;
    end
  end

`ifdef BANK_MACHINE_STATS_EN
  // ---------------- statistics ----------------
  logic acted;  // an ACT was issued since the previous RD/WR

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_acts   <= '0;
      acted       <= 1'b0;
    end else begin
      if (act_acc) begin
        acted <= 1'b1;
        if (~&stat_acts) stat_acts <= stat_acts + 1'b1;
      end
      if (consumed) begin
        acted <= 1'b0;
        if (!acted && ~&stat_hits) stat_hits <= stat_hits + 1'b1;
      end
      if (state != PRECHARGE && state_nxt == PRECHARGE && ~&stat_misses)
        stat_misses <= stat_misses + 1'b1;
    end
  end
`endif

endmodule
